div_ctrl: RTL and testbench

//  Sequencer for the restoring shift-subtract divider. Drives A (remainder), Q (dividend/quotient)
//  and M (divisor) shift_reg instances plus the A-M subtractor through load/sl/clr/shiftIn controls.

---
 rtl/div_ctrl_pkg.sv | 15 +
 rtl/div_iter_cnt.sv | 38 +++
 rtl/div_ctrl.sv | 121 ++++++++++++
 tb/tb_div_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the restoring divider sequencer:
// FSM state encodings and the default operand width.
package div_ctrl_pkg;

    localparam int NBIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TEST  = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_iter_cnt.sv
// Iteration down-counter for the divider sequencer.
// Loads NBIT, decrements once per iteration, flags the final one.
module div_iter_cnt #(
    parameter int NBIT = 16
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    localparam int CW = $clog2(NBIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(NBIT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q == 1 means the iteration now in TEST is the last one
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the restoring shift-subtract divider.
// Drives A/Q/M shift registers; datapath samples on the following negedge.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int nBit = NBIT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic divisor_zero,
    input  logic borrow,
    input  logic q_msb,
    output logic a_clr,
    output logic a_load,
    output logic a_sl,
    output logic a_shift_in,
    output logic q_load,
    output logic q_sl,
    output logic q_shift_in,
    output logic m_load,
    output logic busy,
    output logic done,
    output logic dbz
);

    div_state_e state_q;
    div_state_e state_d;
    logic       dbz_q;
    logic       dbz_d;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;

    div_iter_cnt #(
        .NBIT   (nBit)
    ) u_cnt (
        .clk_i  (clk),
        .clr_i  (clr),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dbz_d      = dbz_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_sl       = 1'b0;
        a_shift_in = 1'b0;
        q_load     = 1'b0;
        q_sl       = 1'b0;
        q_shift_in = 1'b0;
        m_load     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    dbz_d   = 1'b0;
                end
            end
            LOAD: begin
                a_clr  = 1'b1;
                q_load = 1'b1;
                m_load = 1'b1;
                busy   = 1'b1;
                if (divisor_zero) begin
                    state_d = DONE;
                    dbz_d   = 1'b1;
                end else begin
                    state_d  = SHIFT;
                    cnt_load = 1'b1;
                end
            end
            SHIFT: begin
                a_sl       = 1'b1;
                a_shift_in = q_msb;
                busy       = 1'b1;
                state_d    = TEST;
            end
            TEST: begin
                // on borrow A keeps its shifted value (restore by not loading)
                q_sl       = 1'b1;
                q_shift_in = ~borrow;
                a_load     = ~borrow;
                busy       = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbz = dbz_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural negedge A/Q/M datapath.
// nBit = 16; A is kept one bit wider so the compare sees the shifted-out bit.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int NB = 16;

    logic clk = 1'b0;
    logic clr;
    logic start;
    logic divisor_zero;
    logic borrow;
    logic q_msb;
    logic a_clr, a_load, a_sl, a_shift_in;
    logic q_load, q_sl, q_shift_in, m_load;
    logic busy, done, dbz;

    logic        dp_clr;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [16:0] a_r;
    logic [15:0] q_r;
    logic [15:0] m_r;

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int sl_cnt = 0;
    int lat;
    int n0;
    int done_t[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_ctrl #(
        .nBit         (NB)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .divisor_zero (divisor_zero),
        .borrow       (borrow),
        .q_msb        (q_msb),
        .a_clr        (a_clr),
        .a_load       (a_load),
        .a_sl         (a_sl),
        .a_shift_in   (a_shift_in),
        .q_load       (q_load),
        .q_sl         (q_sl),
        .q_shift_in   (q_shift_in),
        .m_load       (m_load),
        .busy         (busy),
        .done         (done),
        .dbz          (dbz)
    );

    always @(negedge clk) begin
        if (dp_clr) begin
            a_r <= '0;
            q_r <= '0;
            m_r <= '0;
        end else begin
            if (a_clr)       a_r <= '0;
            else if (a_load) a_r <= a_r - {1'b0, m_r};
            else if (a_sl)   a_r <= {a_r[15:0], a_shift_in};
            if (q_load)      q_r <= dividend;
            else if (q_sl)   q_r <= {q_r[14:0], q_shift_in};
            if (m_load)      m_r <= divisor;
        end
    end

    assign divisor_zero = (m_r == 16'd0);
    assign borrow       = (a_r < {1'b0, m_r});
    assign q_msb        = q_r[15];

    always @(negedge clk) begin
        if (done) done_t.push_back(cyc);
        if (a_sl || q_sl) sl_cnt++;
        assert (($countones({a_clr, a_load, a_sl}) <= 1) && !(q_load && q_sl))
        else begin
            miss++;
            $error("FAIL ctl_overlap observed=%b expected=no overlap",
                   {a_clr, a_load, a_sl, q_load, q_sl});
        end
    end

    function automatic logic [9:0] ctl_vec();
        return {a_clr, a_load, a_sl, a_shift_in, q_load,
                q_sl, q_shift_in, m_load, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_div(input logic [15:0] dd, input logic [15:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // returns cycles after the edge that sampled start; 100 means timeout
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr      = 1'b1;
        dp_clr   = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_ctl", 32'(ctl_vec()), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_cnt", 32'(dut.u_cnt.cnt_q), 32'd0);
        clr    = 1'b0;
        dp_clr = 1'b0;
        tick();

        // T1: 100 / 7
        start_div(16'd100, 16'd7);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("t1_lat", 32'(lat inside {33, 34}), 32'd1);
        chk("t1_q", 32'(q_r), 32'd14);
        chk("t1_a", 32'(a_r), 32'd2);
        chk("t1_dbz", 32'(dbz), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(dut.state_q), 32'(IDLE));

        // T2: all-ones dividend
        start_div(16'hFFFF, 16'd1);
        wait_done(lat);
        chk("t2a_lat", 32'(lat inside {33, 34}), 32'd1);
        chk("t2a_q", 32'(q_r), 32'hFFFF);
        chk("t2a_a", 32'(a_r), 32'd0);
        tick();
        start_div(16'hFFFF, 16'hFFFF);
        wait_done(lat);
        chk("t2b_lat", 32'(lat inside {33, 34}), 32'd1);
        chk("t2b_q", 32'(q_r), 32'd1);
        chk("t2b_a", 32'(a_r), 32'd0);
        tick();

        // T3: divide by zero, then recovery
        sl_cnt = 0;
        start_div(16'd5, 16'd0);
        wait_done(lat);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_dbz", 32'(dbz), 32'd1);
        chk("t3_no_shift", 32'(sl_cnt), 32'd0);
        tick();
        chk("t3_dbz_hold", 32'(dbz), 32'd1);
        start_div(16'd5, 16'd1);
        chk("t3_dbz_clr", 32'(dbz), 32'd0);
        wait_done(lat);
        chk("t3_q", 32'(q_r), 32'd5);
        chk("t3_a", 32'(a_r), 32'd0);
        tick();

        // T4: dividend < divisor, start re-pulsed while busy
        n0 = done_t.size();
        start_div(16'd3, 16'd10);
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("t4_q", 32'(q_r), 32'd0);
        chk("t4_a", 32'(a_r), 32'd3);
        repeat (6) tick();
        chk("t4_one_done", 32'(done_t.size() - n0), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);

        // T5: abort mid-divide, then clean restart
        start_div(16'd100, 16'd7);
        repeat (9) tick();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_ctl", 32'(ctl_vec()), 32'd0);
        chk("t5_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        chk("t5_stay_idle", 32'(busy), 32'd0);
        dp_clr = 1'b1;
        tick();
        dp_clr = 1'b0;
        start_div(16'd100, 16'd7);
        wait_done(lat);
        chk("t5_q", 32'(q_r), 32'd14);
        chk("t5_a", 32'(a_r), 32'd2);
        tick();

        // T6: start held high for back-to-back divisions
        done_t.delete();
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_t.size() >= 3) break;
        end
        start = 1'b0;
        chk("t6_count", 32'(done_t.size()), 32'd3);
        if (done_t.size() >= 3) begin
            chk("t6_gap1", 32'(done_t[1] - done_t[0]), 32'(2 * NB + 3));
            chk("t6_gap2", 32'(done_t[2] - done_t[1]), 32'(2 * NB + 3));
        end
        chk("t6_q", 32'(q_r), 32'd14);
        tick();
        tick();
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
